// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the RISC-V immediate-generation stage.
package imm_gen_pkg;

    // Internal datapath width; narrower configurations use the low bits.
    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ILL   = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // One decoded instruction; fields are XLEN_MAX wide and sliced to XLEN at the ports.
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        imm_fmt_e            fmt;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] target;
        logic                illegal;
    } imm_result_t;

    // Sign-extend a 32-bit pre-extended immediate to the internal width.
    function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
        return {{(XLEN_MAX-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational instruction-format decode and immediate/target generation.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit PC_REL = 1'b1
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output imm_result_t     result
);

    imm_fmt_e            fmt;
    logic [31:0]         raw32;
    logic [XLEN_MAX-1:0] imm64;
    logic [XLEN_MAX-1:0] pc64;
    logic [2:0]          funct3;

    assign funct3 = instr[14:12];

    // Classify the instruction format from the opcode (and funct3 for shifts).
    always_comb begin
        fmt = FMT_ILL;
        unique case (instr[6:0])
            OP_REG:                       fmt = FMT_R;
            OP_LOAD, OP_JALR, OP_SYSTEM:  fmt = FMT_I;
            OP_IMM:                       fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
            OP_STORE:                     fmt = FMT_S;
            OP_BRANCH:                    fmt = FMT_B;
            OP_LUI, OP_AUIPC:             fmt = FMT_U;
            OP_JAL:                       fmt = FMT_J;
            default:                      fmt = FMT_ILL;
        endcase
    end

    // Assemble the immediate, then extend it and form the PC-relative target.
    always_comb begin
        raw32 = '0;
        unique case (fmt)
            FMT_I:   raw32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   raw32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   raw32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:   raw32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:   raw32 = {instr[31:12], 12'b0};
            default: raw32 = '0;
        endcase

        imm64 = sext32(raw32);
        if (fmt == FMT_SHAMT) begin
            // Shift amounts are unsigned; RV64 uses one extra shamt bit.
            imm64 = '0;
            if (XLEN == 32) begin
                imm64[4:0] = instr[24:20];
            end else begin
                imm64[5:0] = instr[25:20];
            end
        end

        pc64 = '0;
        pc64[XLEN-1:0] = pc;

        result.imm     = imm64;
        result.fmt     = fmt;
        result.pc      = pc64;
        result.target  = PC_REL ? (pc64 + imm64) : '0;
        result.illegal = (fmt == FMT_ILL);
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a one-entry skid buffer.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit PC_REL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    imm_result_t dec_result;
    imm_result_t main_q, main_d;
    imm_result_t skid_q, skid_d;
    logic        main_valid_q, main_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        accept;
    logic        main_free;

    imm_decode #(
        .XLEN   (XLEN),
        .PC_REL (PC_REL)
    ) u_decode (
        .instr  (in_instr),
        .pc     (in_pc),
        .result (dec_result)
    );

    // Ready depends only on the skid flop and reset, never on out_ready.
    assign in_ready  = rst_n & ~skid_valid_q;
    assign accept    = in_valid & in_ready;
    assign main_free = ~main_valid_q | out_ready;

    // Next-state for main and skid entries; flush wins over everything.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // Skid is older than anything arriving now (in_ready was low).
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec_result;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Main is stalled: park the new result in the skid entry.
            skid_d       = dec_result;
            skid_valid_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset clearing data too.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm[XLEN-1:0];
    assign out_fmt     = main_q.fmt;
    assign out_pc      = main_q.pc[XLEN-1:0];
    assign out_target  = main_q.target[XLEN-1:0];
    assign out_illegal = main_q.illegal;

    // Upper internal bits are unused when XLEN is narrower than the struct.
    generate
        if (XLEN < XLEN_MAX) begin : g_narrow
            logic unused_hi;
            assign unused_hi = ^{main_q.imm[XLEN_MAX-1:XLEN],
                                 main_q.pc[XLEN_MAX-1:XLEN],
                                 main_q.target[XLEN_MAX-1:XLEN]};
        end
    endgenerate

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage (XLEN=32 and XLEN=64 instances).
module tb_imm_gen_stage;

    logic        clk;
    logic        rst_n;

    logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_imm, out_pc, out_target;
    logic [2:0]  out_fmt;

    logic        flush_w, in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_illegal_w;
    logic [31:0] in_instr_w;
    logic [63:0] in_pc_w, out_imm_w, out_pc_w, out_target_w;
    logic [2:0]  out_fmt_w;

    int checks   = 0;
    int failures = 0;

    imm_gen_stage #(.XLEN(32), .PC_REL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_pc(out_pc), .out_target(out_target), .out_illegal(out_illegal)
    );

    imm_gen_stage #(.XLEN(64), .PC_REL(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .in_instr(in_instr_w), .in_pc(in_pc_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_imm(out_imm_w), .out_fmt(out_fmt_w),
        .out_pc(out_pc_w), .out_target(out_target_w), .out_illegal(out_illegal_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send64(input logic [31:0] instr, input logic [63:0] pc);
        in_valid_w = 1'b1;
        in_instr_w = instr;
        in_pc_w    = pc;
        tick();
        in_valid_w = 1'b0;
    endtask

    task automatic expect32(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                            input logic [31:0] pc, input logic [31:0] tgt, input logic ill);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_imm"}, 64'(out_imm), 64'(imm));
        chk({tag, "_fmt"}, 64'(out_fmt), 64'(fmt));
        chk({tag, "_pc"}, 64'(out_pc), 64'(pc));
        chk({tag, "_tgt"}, 64'(out_target), 64'(tgt));
        chk({tag, "_ill"}, 64'(out_illegal), 64'(ill));
        $display("txn %s imm=%h fmt=%0d pc=%h target=%h illegal=%0d", tag, out_imm, out_fmt, out_pc, out_target, out_illegal);
    endtask

    initial begin
        int          sent;
        int          got;
        bit          prev_stall;
        bit          saw_block;
        logic [31:0] prev_imm;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'h0; in_pc = 32'h0;
        flush_w = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b1;
        in_instr_w = 32'h0; in_pc_w = 64'h0;

        // Reset behaviour
        #1;
        chk("rst_in_ready_before_edge", 64'(in_ready), 64'd0);
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_target", 64'(out_target), 64'd0);
        chk("rst_fmt", 64'(out_fmt), 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        chk("rst_w_out_valid", 64'(out_valid_w), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_in_ready_w", 64'(in_ready_w), 64'd1);

        // Directed formats, XLEN=32
        send32(32'hFFF00093, 32'h100); expect32("addi",  32'hFFFFFFFF, 3'd1, 32'h100,  32'h000000FF, 1'b0);
        send32(32'hFE000EE3, 32'h200); expect32("beq",   32'hFFFFFFFC, 3'd3, 32'h200,  32'h000001FC, 1'b0);
        send32(32'h0080006F, 32'h010); expect32("jal",   32'h00000008, 3'd5, 32'h010,  32'h00000018, 1'b0);
        send32(32'hFE112C23, 32'h020); expect32("sw",    32'hFFFFFFF8, 3'd2, 32'h020,  32'h00000018, 1'b0);
        send32(32'h12345017, 32'h1000); expect32("auipc", 32'h12345000, 3'd4, 32'h1000, 32'h12346000, 1'b0);
        send32(32'h4010D093, 32'h030); expect32("srai",  32'h00000001, 3'd6, 32'h030,  32'h00000031, 1'b0);
        send32(32'h002081B3, 32'h040); expect32("add",   32'h00000000, 3'd0, 32'h040,  32'h00000040, 1'b0);
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        // Directed formats, XLEN=64
        send64(32'h800002B7, 64'h0);
        chk("lui64_imm", out_imm_w, 64'hFFFFFFFF80000000);
        chk("lui64_fmt", 64'(out_fmt_w), 64'd4);
        $display("txn lui64 imm=%h fmt=%0d", out_imm_w, out_fmt_w);
        send64(32'h03F09093, 64'h0);
        chk("slli64_imm", out_imm_w, 64'd63);
        chk("slli64_fmt", 64'(out_fmt_w), 64'd6);
        $display("txn slli64 imm=%h fmt=%0d", out_imm_w, out_fmt_w);
        send64(32'hFE000EE3, 64'h1_0000_0000);
        chk("beq64_imm", out_imm_w, 64'hFFFFFFFFFFFFFFFC);
        chk("beq64_tgt", out_target_w, 64'h0000_0000_FFFF_FFFC);
        $display("txn beq64 imm=%h target=%h", out_imm_w, out_target_w);

        // Backpressure stream: 6 instructions, out_ready low in cycles 2..4
        sent = 0; got = 0; prev_stall = 1'b0; saw_block = 1'b0; prev_imm = 32'h0;
        for (int c = 0; c < 14; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            if (sent < 6) begin
                in_valid = 1'b1;
                in_instr = (32'(sent + 1) << 20) | 32'h00000093;
                in_pc    = 32'h400 + 32'(4 * (sent + 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_imm", 64'(out_imm), 64'(prev_imm));
            end
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                got++;
                chk("bp_imm", 64'(out_imm), 64'(got));
                chk("bp_pc", 64'(out_pc), 64'(32'h400 + 32'(4 * got)));
                $display("txn bp cycle=%0d imm=%h pc=%h", c, out_imm, out_pc);
            end
            prev_stall = out_valid && !out_ready;
            prev_imm   = out_imm;
            if (in_valid && in_ready) sent++;
            tick();
        end
        chk("bp_count", 64'(got), 64'd6);
        chk("bp_in_ready_dropped", 64'(saw_block), 64'd1);
        chk("bp_in_ready_end", 64'(in_ready), 64'd1);

        // Flush with main and skid both full and in_valid high
        out_ready = 1'b0;
        send32(32'h00700093, 32'h600);
        in_valid = 1'b1; in_instr = 32'h00800093; in_pc = 32'h604;
        tick();
        chk("fl_skid_full_in_ready", 64'(in_ready), 64'd0);
        chk("fl_main_hold_imm", 64'(out_imm), 64'd7);
        in_instr = 32'h00900093; in_pc = 32'h608; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        $display("txn flush out_valid=%0d in_ready=%0d", out_valid, in_ready);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_reappear", 64'(out_valid), 64'd0);
        end

        // Flush beats acceptance of a presented input
        in_valid = 1'b1; in_instr = 32'h00A00093; in_pc = 32'h700; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_prio_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("fl_prio_later", 64'(out_valid), 64'd0);

        // Illegal opcode, then reset mid-stall
        out_ready = 1'b0;
        send32(32'h0000007F, 32'h300); expect32("ill", 32'h0, 3'd7, 32'h300, 32'h300, 1'b1);
        in_valid = 1'b1; in_instr = 32'h00B00093; in_pc = 32'h304;
        tick();
        in_valid = 1'b0;
        chk("ill_skid_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready_after_edge", 64'(in_ready), 64'd0);
        chk("mid_rst_illegal", 64'(out_illegal), 64'd0);
        chk("mid_rst_fmt", 64'(out_fmt), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_release_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send32(32'h00500093, 32'h500); expect32("fresh", 32'h5, 3'd1, 32'h500, 32'h505, 1'b0);
        tick();
        chk("fresh_no_stale", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered RISC-V immediate-generation stage between fetch and execute.
- Decodes the instruction format from the opcode, so no external format select.
- Builds the XLEN-wide immediate, including U-type and shift-amount forms.
- Computes the PC-relative target.
- Passes results downstream through a valid/ready pipeline register with a skid buffer, so throughput is one instruction per cycle under backpressure.

Parameters:
XLEN, 32, datapath width: 32 or 64. Immediates are sign-extended to XLEN.
PC_REL, 1, 1 = out_target computed; 0 = out_target tied to 0 and adder removed.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
flush  in  1  synchronous pipeline kill
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_imm  out  XLEN  extended immediate
out_fmt  out  3  imm_fmt_e: R=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, ILL=7
out_pc  out  XLEN  registered in_pc
out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
out_illegal  out  1  opcode not recognised

Behaviour:
- Opcode map, in_instr[6:0]:
  - 0110011 -> R; imm = 0.
  - 0000011, 1100111, 1110011 -> I.
  - 0010011 -> I, except funct3 001/101 -> SHAMT.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - Anything else -> ILL; imm = 0, illegal = 1.
- Immediates (before extension to XLEN):
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U = {instr[31:12], 12'b0}.
- Extension:
  - All formats except SHAMT are sign-extended from the top bit to XLEN.
  - SHAMT is zero-extended: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
- Target: out_target = in_pc + imm, computed combinationally on the input side and registered. It is meaningful for B, J and AUIPC; don't-care for other formats.
- Latency: 1 cycle. An input accepted on edge N is visible on outputs after edge N (out_valid = 1).
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_valid and out_* hold stable while out_valid & !out_ready.
- Skid buffer (one entry):
  - in_ready = !skid_valid, taken directly from a register with no combinational path from out_ready.
  - If an input is accepted while the main register is full and stalled, the decoded result goes to the skid entry.
  - When the main register drains, the skid entry moves into it on the same edge and skid_valid clears.
  - Order is preserved; no drops and no duplicates.
- Simultaneous events:
  - Main register full, out_ready = 1 and input accepted on the same edge: main loads the new input, and skid stays empty.
  - Skid full: in_ready = 0, so no input is accepted.
- Flush:
  - On the next edge, main and skid valid bits clear and any input presented that cycle is discarded. Flush has priority over acceptance.
  - out_valid = 0 and in_ready = 1 in the following cycle.
  - Data registers are not cleared.
- Reset:
  - While rst_n = 0: in_ready = 0.
  - After the first edge with rst_n = 0: out_valid = 0, skid_valid = 0, and out_imm, out_pc, out_target, out_fmt (= R), out_illegal all = 0.
  - Reset mid-transfer drops in-flight entries.
  - in_ready = 1 from the first cycle with rst_n = 1.
- X-safety: in_instr and in_pc are ignored when in_valid = 0. No state changes.

Decomposition:
- Package imm_gen_pkg: imm_fmt_e enum; opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM); a packed result struct {imm, fmt, pc, target, illegal} used for both the main and skid registers.
- Sub-module imm_decode: purely combinational, parameterised by XLEN. Maps (instr, pc) to the result struct. The pipeline/skid control stays in imm_gen_stage.

Test Plan:
- I-type, XLEN=32: instr 0xFFF00093 (addi x1,x0,-1), pc 0x100 -> one cycle later out_imm 0xFFFFFFFF, fmt I, target 0x000000FF.
- B and J: instr 0xFE000EE3 (beq x0,x0,-4), pc 0x200 -> imm 0xFFFFFFFC, target 0x1FC. Instr 0x0080006F (jal +8), pc 0x10 -> imm 8, target 0x18.
- U/SHAMT, XLEN=64: instr 0x800002B7 (lui) -> imm 0xFFFFFFFF80000000. Instr 0x03F09093 (slli x1,x1,63) -> fmt SHAMT, imm 63, not sign-extended.
- Backpressure: stream of 6 instructions with out_ready low for cycles 2-4:
  - in_ready drops after the skid fills.
  - All 6 emerge in order, exactly once.
  - Outputs hold stable while stalled.
- Flush with main and skid both full and in_valid high -> next cycle out_valid = 0, in_ready = 1, and none of the three appears later.
- Illegal opcode 0x0000007F -> out_illegal = 1, fmt ILL, imm 0. Then rst_n low for one cycle mid-stall -> out_valid = 0, in_ready = 0 during reset, and a fresh stream is accepted afterwards.
